// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard sequencer for the five-stage pipeline. It inserts load-use bubbles,
//   flushes wrong-path instructions on a taken BEQ in EX/MEM, and freezes the
//   whole pipe while data memory is not ready.
// Ports
//   clock, reset      rising-edge clock, asynchronous active-low reset
//   ifid_inst         instruction in IF/ID
//   idex_inst         instruction in ID/EX
//   exmem_inst        instruction in EX/MEM
//   branch_taken      EX/MEM BEQ condition (only meaningful for BEQ)
//   mem_ready         data memory completes the EX/MEM LW/SW this cycle
//   pc_write          PC update enable
//   ifid_write        IF/ID load enable
//   idex_bubble       load NOP into ID/EX
//   ifid_flush        load NOP into IF/ID
//   exmem_flush       load NOP into EX/MEM
//   pipe_hold         hold ID/EX, EX/MEM, MEM/WB
//   mem_error         sticky memory timeout flag
//   stall_cycles      saturating count of cycles with pc_write low
//
// state       | meaning
// ST_RUN      | normal flow; single-cycle hazards are handled here
// ST_LU_STALL | remaining load-use bubbles (LU_STALL_CYCLES > 1)
// ST_MEM_WAIT | pipe frozen waiting for data memory
module pipeline_hazard_ctrl #(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 15,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      ifid_inst,
  input  logic [31:0]      idex_inst,
  input  logic [31:0]      exmem_inst,
  input  logic             branch_taken,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             exmem_flush,
  output logic             pipe_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 2);

  typedef enum logic [1:0] {ST_RUN, ST_LU_STALL, ST_MEM_WAIT} state_t;

  state_t             state_q, state_d;
  logic [1:0]         lu_cnt_q, lu_cnt_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_error_q, mem_error_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic pc_write_c, ifid_write_c, bubble_c, ifid_flush_c, exmem_flush_c, hold_c;

  logic [5:0] ifid_op, idex_op, exmem_op;
  logic [4:0] ifid_rs, ifid_rt, idex_rt;
  logic       load_use, mem_busy, br, timeout;
  logic       unused_bits;

  assign ifid_op  = ifid_inst[31:26];
  assign ifid_rs  = ifid_inst[25:21];
  assign ifid_rt  = ifid_inst[20:16];
  assign idex_op  = idex_inst[31:26];
  assign idex_rt  = idex_inst[20:16];
  assign exmem_op = exmem_inst[31:26];
  assign unused_bits = ^{ifid_inst[15:0], idex_inst[25:21], idex_inst[15:0], exmem_inst[25:0]};

  // rt is only a source operand for R-type, BEQ and SW; for I-type ALU ops it is the destination.
  assign load_use = (idex_op == OP_LW) && (idex_rt != 5'd0) &&
                    ((ifid_rs == idex_rt) ||
                     ((ifid_rt == idex_rt) &&
                      (ifid_op == OP_SPECIAL || ifid_op == OP_BEQ || ifid_op == OP_SW)));
  assign mem_busy = (exmem_op == OP_LW || exmem_op == OP_SW) && !mem_ready;
  assign br       = (exmem_op == OP_BEQ) && branch_taken;
  assign timeout  = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_W'(MEM_TIMEOUT));

  always_comb begin
    state_d       = state_q;
    lu_cnt_d      = lu_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    mem_error_d   = mem_error_q;
    pc_write_c    = 1'b1;
    ifid_write_c  = 1'b1;
    bubble_c      = 1'b0;
    ifid_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    hold_c        = 1'b0;
    case (state_q)
      ST_RUN, ST_LU_STALL: begin
        if (mem_busy) begin
          // lu_cnt is left untouched so a preempted load-use stall resumes afterwards
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          hold_c       = 1'b1;
          wait_cnt_d   = WAIT_W'(1);
          state_d      = ST_MEM_WAIT;
        end else if (br) begin
          ifid_flush_c  = 1'b1;
          bubble_c      = 1'b1;
          exmem_flush_c = 1'b1;
          lu_cnt_d      = 2'd0;
          state_d       = ST_RUN;
        end else if (state_q == ST_LU_STALL) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          bubble_c     = 1'b1;
          if (lu_cnt_q == 2'(LU_STALL_CYCLES - 1)) begin
            lu_cnt_d = 2'd0;
            state_d  = ST_RUN;
          end else begin
            lu_cnt_d = lu_cnt_q + 2'd1;
          end
        end else if (load_use) begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          bubble_c     = 1'b1;
          if (LU_STALL_CYCLES > 1) begin
            lu_cnt_d = 2'd1;
            state_d  = ST_LU_STALL;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (!mem_busy || timeout) begin
          if (mem_busy) mem_error_d = 1'b1;
          wait_cnt_d = '0;
          state_d    = (lu_cnt_q != 2'd0) ? ST_LU_STALL : ST_RUN;
        end else begin
          pc_write_c   = 1'b0;
          ifid_write_c = 1'b0;
          hold_c       = 1'b1;
          if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase
    stall_d = stall_q;
    if (!pc_write_c && (stall_q != '1)) stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      lu_cnt_q    <= 2'd0;
      wait_cnt_q  <= '0;
      mem_error_q <= 1'b0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_error_q <= mem_error_d;
      stall_q     <= stall_d;
    end
  end

  // Outputs are forced low for as long as reset is asserted.
  assign pc_write     = reset & pc_write_c;
  assign ifid_write   = reset & ifid_write_c;
  assign idex_bubble  = reset & bubble_c & ~hold_c;
  assign ifid_flush   = reset & ifid_flush_c;
  assign exmem_flush  = reset & exmem_flush_c;
  assign pipe_hold    = reset & hold_c;
  assign mem_error    = mem_error_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic        clock, reset;
  logic [31:0] ifid_inst, idex_inst, exmem_inst;
  logic        branch_taken, mem_ready;

  logic        pc1, iw1, bub1, iff1, exf1, hold1, err1;
  logic        pc3, iw3, bub3, iff3, exf3, hold3, err3;
  logic [15:0] stall1, stall3;
  logic [5:0]  o1, o3;

  int checks = 0;
  int errors = 0;
  int st1 = 0;
  int st3 = 0;

  // {pc_write, ifid_write, idex_bubble, ifid_flush, exmem_flush, pipe_hold}
  localparam logic [5:0] ZERO  = 6'b000000;
  localparam logic [5:0] RUNO  = 6'b110000;
  localparam logic [5:0] LUO   = 6'b001000;
  localparam logic [5:0] BRO   = 6'b111110;
  localparam logic [5:0] HOLDO = 6'b000001;
  localparam logic [31:0] NOP  = 32'h0;

  assign o1 = {pc1, iw1, bub1, iff1, exf1, hold1};
  assign o3 = {pc3, iw3, bub3, iff3, exf3, hold3};

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(15), .CNT_W(16)) u_dut1 (
    .clock(clock), .reset(reset), .ifid_inst(ifid_inst), .idex_inst(idex_inst),
    .exmem_inst(exmem_inst), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pc1), .ifid_write(iw1), .idex_bubble(bub1), .ifid_flush(iff1),
    .exmem_flush(exf1), .pipe_hold(hold1), .mem_error(err1), .stall_cycles(stall1));

  pipeline_hazard_ctrl #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(15), .CNT_W(16)) u_dut3 (
    .clock(clock), .reset(reset), .ifid_inst(ifid_inst), .idex_inst(idex_inst),
    .exmem_inst(exmem_inst), .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pc3), .ifid_write(iw3), .idex_bubble(bub3), .ifid_flush(iff3),
    .exmem_flush(exf3), .pipe_hold(hold3), .mem_error(err3), .stall_cycles(stall3));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] r_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    return {6'b000000, rs, rt, rd, 11'h020};
  endfunction
  function automatic logic [31:0] i_lw(input logic [4:0] base, input logic [4:0] rt);
    return {6'b100011, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] i_sw(input logic [4:0] base, input logic [4:0] rt);
    return {6'b101011, base, rt, 16'h0000};
  endfunction
  function automatic logic [31:0] i_beq(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b000100, rs, rt, 16'h0004};
  endfunction
  function automatic logic [31:0] i_addi(input logic [4:0] rs, input logic [4:0] rt);
    return {6'b001000, rs, rt, 16'h0001};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check both instances mid-cycle, then advance past the edge.
  task automatic step(input string tag, input logic [5:0] e1, input logic [5:0] e3);
    @(negedge clock);
    chk({tag, "/lu1"}, {26'd0, o1}, {26'd0, e1});
    chk({tag, "/lu3"}, {26'd0, o3}, {26'd0, e3});
    @(posedge clock);
    #1;
    if (!e1[5]) st1++;
    if (!e3[5]) st3++;
  endtask

  // First bubble with the hazard present, then ID/EX holds the bubble.
  task automatic lu_seq(input string tag);
    step({tag, "_b0"}, LUO, LUO);
    idex_inst = NOP;
    step({tag, "_b1"}, RUNO, LUO);
    step({tag, "_b2"}, RUNO, LUO);
    step({tag, "_end"}, RUNO, RUNO);
  endtask

  task automatic clear_inputs();
    ifid_inst = NOP; idex_inst = NOP; exmem_inst = NOP;
    branch_taken = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    #3;
    chk("rst_out1", {26'd0, o1}, {26'd0, ZERO});
    chk("rst_out3", {26'd0, o3}, {26'd0, ZERO});
    chk("rst_stall", {16'd0, stall1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    step("idle", RUNO, RUNO);

    // load-use via rs
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = r_add(5'd2, 5'd4, 5'd3);
    lu_seq("lu_rs");
    chk("stall1_lu", {16'd0, stall1}, 32'd1);
    chk("stall3_lu", {16'd0, stall3}, 32'd3);

    // lw to $0 never stalls
    idex_inst = i_lw(5'd1, 5'd0); ifid_inst = r_add(5'd0, 5'd0, 5'd3);
    step("lw_r0", RUNO, RUNO);
    // addi uses rt as destination: no hazard through rt
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = i_addi(5'd5, 5'd2);
    step("addi_rt", RUNO, RUNO);
    ifid_inst = i_addi(5'd2, 5'd3);
    lu_seq("addi_rs");
    // SW data source through rt
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = i_sw(5'd5, 5'd2);
    lu_seq("sw_rt");
    ifid_inst = NOP;

    // taken branch, non-BEQ with branch_taken, untaken BEQ
    exmem_inst = i_beq(5'd1, 5'd2); branch_taken = 1'b1;
    step("beq_taken", BRO, BRO);
    exmem_inst = r_add(5'd1, 5'd2, 5'd3);
    step("nonbeq_bt", RUNO, RUNO);
    exmem_inst = i_beq(5'd1, 5'd2); branch_taken = 1'b0;
    step("beq_nt", RUNO, RUNO);

    // SW waits four cycles
    clear_inputs();
    exmem_inst = i_sw(5'd1, 5'd2);
    for (int i = 0; i < 4; i++) step("sw_wait", HOLDO, HOLDO);
    mem_ready = 1'b1;
    step("sw_release", RUNO, RUNO);
    exmem_inst = NOP; mem_ready = 1'b0;
    step("after_sw", RUNO, RUNO);
    chk("stall1_sw", {16'd0, stall1}, st1);
    chk("stall3_sw", {16'd0, stall3}, st3);

    // branch beats load-use
    exmem_inst = i_beq(5'd1, 5'd2); branch_taken = 1'b1;
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = r_add(5'd2, 5'd4, 5'd3);
    step("br_vs_lu", BRO, BRO);
    clear_inputs();
    step("br_vs_lu_after", RUNO, RUNO);

    // memory stall in the middle of a multi-cycle load-use stall
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = r_add(5'd2, 5'd4, 5'd3);
    step("lum_b0", LUO, LUO);
    idex_inst = NOP; exmem_inst = i_lw(5'd3, 5'd7);
    step("lum_hold0", HOLDO, HOLDO);
    step("lum_hold1", HOLDO, HOLDO);
    mem_ready = 1'b1;
    step("lum_release", RUNO, RUNO);
    exmem_inst = NOP; mem_ready = 1'b0;
    step("lum_b1", RUNO, LUO);
    step("lum_b2", RUNO, LUO);
    step("lum_end", RUNO, RUNO);

    // branch cancels the remaining bubbles
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = r_add(5'd2, 5'd4, 5'd3);
    step("lub_b0", LUO, LUO);
    idex_inst = NOP; exmem_inst = i_beq(5'd1, 5'd2); branch_taken = 1'b1;
    step("lub_br", BRO, BRO);
    clear_inputs();
    step("lub_end", RUNO, RUNO);

    // memory timeout
    exmem_inst = i_lw(5'd1, 5'd2);
    for (int i = 0; i < 15; i++) step("to_hold", HOLDO, HOLDO);
    chk("err_before_to", {30'd0, err1, err3}, 32'd0);
    step("to_release", RUNO, RUNO);
    exmem_inst = NOP;
    chk("err_after_to", {30'd0, err1, err3}, 32'd3);
    step("to_resume", RUNO, RUNO);
    chk("err_sticky", {30'd0, err1, err3}, 32'd3);
    chk("stall1_to", {16'd0, stall1}, st1);
    chk("stall3_to", {16'd0, stall3}, st3);

    // reset in the middle of a wait that preempted a load-use stall
    idex_inst = i_lw(5'd1, 5'd2); ifid_inst = r_add(5'd2, 5'd4, 5'd3);
    step("rw_b0", LUO, LUO);
    idex_inst = NOP; exmem_inst = i_sw(5'd1, 5'd2);
    step("rw_hold0", HOLDO, HOLDO);
    step("rw_hold1", HOLDO, HOLDO);
    #2;
    reset = 1'b0;
    #1;
    chk("rw_out1", {26'd0, o1}, {26'd0, ZERO});
    chk("rw_out3", {26'd0, o3}, {26'd0, ZERO});
    chk("rw_err", {30'd0, err1, err3}, 32'd0);
    chk("rw_stall", {stall1, stall3}, 32'd0);
    st1 = 0; st3 = 0;
    clear_inputs();
    @(posedge clock); #1;
    reset = 1'b1;
    step("rw_after", RUNO, RUNO);
    step("rw_after2", RUNO, RUNO);
    chk("stall1_end", {16'd0, stall1}, st1);
    chk("stall3_end", {16'd0, stall3}, st3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
